pipelined_wallace_mul: RTL and testbench
========================================

# pipelined_wallace_mul

Parametrised, pipelined Wallace-tree multiplier for the Tomasulo integer multiply functional unit. It accepts one WIDTH×WIDTH operation per cycle from the multiply reservation station over a valid/ready handshake. It reduces partial products through registered levels of 3:2 carry-save rows and returns a 2·WIDTH-bit product with the issuing reservation-station tag to the CDB arbiter. It generalises the fixed 32-bit combinational CSA tree with configurable width, pipeline depth, back-pressure, flush and an optional signed mode.

## Interface
Parameters:
- WIDTH, 32: operand width. Legal values are 8, 16, 32 and 64.
- TAG_W, 4: reservation-station tag width.
- LVL_PER_STAGE, 2: number of 3:2 CSA levels between pipeline registers. Must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept this cycle
- in_a, in_b  in  WIDTH  operands
- in_tag  in  TAG_W  reservation-station tag
- in_signed  in  1  two's-complement mode; present only under MUL_SIGNED_EN
- flush  in  1  squash all in-flight operations (mispredict recovery)
- out_valid  out  1  product available
- out_ready  in  1  CDB arbiter takes product
- out_product  out  2·WIDTH  product
- out_tag  out  TAG_W  tag of that product

## Operation
- Pipeline structure:
  - Stage P registers all WIDTH partial-product rows.
  - T tree stages follow, T = ceil(D/LVL_PER_STAGE), where D is the number of 3:2 levels that reduce WIDTH rows to 2. D = 4, 6, 8, 10 for WIDTH = 8, 16, 32, 64.
  - Stage C performs the carry-propagate add and registers the outputs.
  - Each stage carries a valid bit and the tag.
- Global stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance && !flush.
  - All stages shift together when advance is high and hold otherwise.
  - Bubbles are not compressed.
- Transfer rules:
  - An input is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
- Flush:
  - Synchronous. At the next edge every stage valid bit, including out_valid, clears.
  - Input presented during the flush cycle is not accepted, because in_ready is low.
  - Flush overrides out_ready; a product presented in the flush cycle is discarded and must not be counted by the arbiter.
- Width rules:
  - Carry-save rows widen to 2·WIDTH bits.
  - The carry out of bit 2·WIDTH−1 is dropped.
  - The product is exact, because unsigned WIDTH×WIDTH fits in 2·WIDTH bits.
- Reset values:
  - out_valid=0, out_product=0, out_tag=0, all internal valid bits=0.
  - in_ready=1 immediately after reset deasserts.
  - Reset mid-operation discards all in-flight work.
- Data registers may skip reset, except out_product and out_tag, which must reset to 0.

## Timing
- Latency L = T + 2 edges from acceptance to out_valid:
  - WIDTH=32, LVL_PER_STAGE=2: L=6.
  - WIDTH=32, LVL_PER_STAGE=4: L=4.
  - WIDTH=8, LVL_PER_STAGE=2: L=4.
- Throughput is 1 operation per cycle while out_ready stays high.
- While out_valid=1 and out_ready=0:
  - out_product and out_tag hold stable.
  - in_ready=0.
- out_ready may be asserted with out_valid low. It is ignored but still sets advance.
- in_ready depends combinationally on out_ready and flush only, never on in_valid.

## Configuration
- MUL_SIGNED_EN defined:
  - The in_signed port exists and is carried per operation.
  - With in_signed=1, Baugh-Wooley partial products are used: the MSB row and column are inverted, and the correction constant is folded into the row-0 constant bits so the row count stays WIDTH and D is unchanged.
  - out_product is the 2·WIDTH-bit two's-complement product.
  - With in_signed=0, behaviour is unsigned.
- MUL_SIGNED_EN undefined:
  - There is no in_signed port.
  - All operations are unsigned.
  - Latency is identical.

## Structure
- Package mul_pkg holds:
  - a constant function csa_depth(rows) returning D;
  - the stage-count function T;
  - the stage payload typedef (valid, tag, signed flag, carry-save vectors).
- Sub-module csa_row: a parametrised N-bit row of 3:2 full adders. Outputs are sum and carry, with the carry shifted left by one and the LSB set to 0.
- The top instantiates csa_row instances in generate loops per tree level and inserts registers after every LVL_PER_STAGE levels.

## Test plan
- Reset, then a single op with WIDTH=32, LVL=2: a=0xFFFFFFFF, b=0xFFFFFFFF, tag=5 → out_product=0xFFFFFFFE00000001 and out_tag=5 exactly 6 edges after acceptance. in_ready=1 throughout.
- Back-to-back stream of 20 random ops with out_ready=1 → one result per cycle, in order, tags matching, values equal to a reference a·b.
- Back-pressure: fill the pipe, then hold out_ready=0 for 5 cycles:
  - in_ready=0 from the first stalled cycle;
  - out_product is stable;
  - after release, no op is lost or duplicated.
- Flush with 4 ops in flight plus an in_valid op presented in the same cycle:
  - the next cycle has out_valid=0 and that in_valid op is not accepted;
  - an op accepted after the flush returns with its correct tag at latency L.
- With MUL_SIGNED_EN: a=0xFFFFFFFF (−1), b=0x00000003, in_signed=1 → out_product=0xFFFFFFFFFFFFFFFD. The same operands with in_signed=0 → 0x00000002FFFFFFFD.
- Assert rst_n low mid-stream → out_valid=0 and out_product=0 immediately, and in_ready=1 after release.

Source files
------------

// File: rtl/pipelined_wallace_mul_pkg.sv
// Shared constants and helpers for the pipelined Wallace-tree multiplier:
// tree depth, pipeline stage count and the per-stage control payload.
package mul_pkg;

   localparam int MAX_TAG_W = 16;

   // Rows left after lvl levels of 3:2 reduction starting from rows0 rows.
   function automatic int rows_at(input int rows0, input int lvl);
      int r;
      r = rows0;
      for (int k = 0; k < lvl; k++) r = 2 * (r / 3) + (r % 3);
      return r;
   endfunction

   function automatic int csa_depth(input int rows);
      int r;
      int d;
      r = rows;
      d = 0;
      while (r > 2) begin
         r = 2 * (r / 3) + (r % 3);
         d++;
      end
      return d;
   endfunction

   function automatic int n_tree_stages(input int depth, input int lvl_per_stage);
      return (depth + lvl_per_stage - 1) / lvl_per_stage;
   endfunction

   typedef struct packed {
      logic                 valid;
      logic [MAX_TAG_W-1:0] tag;
   } stage_ctl_t;

endpackage

// File: rtl/pipelined_wallace_mul_if.sv
// Request/response bundle between the multiply reservation station, the
// multiplier and the CDB arbiter. MUL_SIGNED_EN adds the in_signed field.
interface pipelined_wallace_mul_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic [TAG_W-1:0]   in_tag;
`ifdef MUL_SIGNED_EN
   logic               in_signed;
`endif
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_product;
   logic [TAG_W-1:0]   out_tag;

`ifdef MUL_SIGNED_EN
   modport master (
      output in_valid, in_a, in_b, in_tag, in_signed, flush, out_ready,
      input  in_ready, out_valid, out_product, out_tag
   );
   modport slave (
      input  in_valid, in_a, in_b, in_tag, in_signed, flush, out_ready,
      output in_ready, out_valid, out_product, out_tag
   );
`else
   modport master (
      output in_valid, in_a, in_b, in_tag, flush, out_ready,
      input  in_ready, out_valid, out_product, out_tag
   );
   modport slave (
      input  in_valid, in_a, in_b, in_tag, flush, out_ready,
      output in_ready, out_valid, out_product, out_tag
   );
`endif
endinterface

// File: rtl/pipelined_wallace_mul_csa_row.sv
// One row of N 3:2 full adders; carry is returned pre-shifted so the carry
// out of the top bit falls off the row.
module csa_row #(
   parameter int N = 64
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic [N-1:0] i_c,
   output logic [N-1:0] o_sum,
   output logic [N-1:0] o_carry
);
   assign o_sum   = i_a ^ i_b ^ i_c;
   assign o_carry = {(i_a[N-2:0] & i_b[N-2:0]) |
                     (i_a[N-2:0] & i_c[N-2:0]) |
                     (i_b[N-2:0] & i_c[N-2:0]), 1'b0};
endmodule

// File: rtl/pipelined_wallace_mul.sv
// Pipelined Wallace-tree multiplier: partial-product stage, registered CSA
// tree, final carry-propagate stage. MUL_SIGNED_EN enables Baugh-Wooley signed ops.
module pipelined_wallace_mul
   import mul_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int TAG_W         = 4,
   parameter int LVL_PER_STAGE = 2
) (
   input logic                    clk,
   input logic                    rst_n,
   pipelined_wallace_mul_if.slave bus
);
   localparam int PW = 2 * WIDTH;
   localparam int D  = csa_depth(WIDTH);
   localparam int T  = n_tree_stages(D, LVL_PER_STAGE);
   localparam int NS = T + 2;

   logic          w_adv;
   logic          w_rdy;
   logic          w_acc;
   logic          w_sgn;
   logic [PW-1:0] w_pp  [WIDTH];
   logic [PW-1:0] r_pp  [WIDTH];
   logic [PW-1:0] w_cur [D+1][WIDTH];
   logic [PW-1:0] r_prod;
   stage_ctl_t    r_ctl [NS];

   assign w_adv = !r_ctl[NS-1].valid || bus.out_ready;
   assign w_rdy = w_adv && !bus.flush;
   assign w_acc = bus.in_valid && w_rdy;

`ifdef MUL_SIGNED_EN
   assign w_sgn = bus.in_signed;
`else
   assign w_sgn = 1'b0;
`endif

   // Signed rows invert the MSB column (rows 0..W-2) or all but the MSB (row W-1);
   // the Baugh-Wooley constants 2^W and 2^(2W-1) ride in row 0's empty upper bits.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         logic [WIDTH-1:0] v_row;
         v_row = bus.in_a & {WIDTH{bus.in_b[i]}};
         if (w_sgn) begin
            if (i == WIDTH - 1) v_row = v_row ^ {1'b0, {(WIDTH-1){1'b1}}};
            else                v_row[WIDTH-1] = ~v_row[WIDTH-1];
         end
         w_pp[i] = PW'(v_row) << i;
      end
      if (w_sgn) begin
         w_pp[0][WIDTH] = 1'b1;
         w_pp[0][PW-1]  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_adv) r_pp <= w_pp;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_l0
      assign w_cur[0][i] = r_pp[i];
   end

   for (genvar k = 0; k < D; k++) begin : g_lvl
      localparam int NI = rows_at(WIDTH, k);
      localparam int NO = rows_at(WIDTH, k + 1);
      localparam int NG = NI / 3;
      logic [PW-1:0] w_nxt [NO];

      for (genvar g = 0; g < NG; g++) begin : g_csa
         csa_row #(.N(PW)) u_csa (
            .i_a     (w_cur[k][3*g]),
            .i_b     (w_cur[k][3*g+1]),
            .i_c     (w_cur[k][3*g+2]),
            .o_sum   (w_nxt[2*g]),
            .o_carry (w_nxt[2*g+1])
         );
      end
      for (genvar r = 3 * NG; r < NI; r++) begin : g_pass
         assign w_nxt[2*NG + r - 3*NG] = w_cur[k][r];
      end

      if (((k + 1) % LVL_PER_STAGE == 0) || (k == D - 1)) begin : g_reg
         logic [PW-1:0] r_q [NO];
         always_ff @(posedge clk) begin
            if (w_adv) r_q <= w_nxt;
         end
         for (genvar r = 0; r < NO; r++) begin : g_o
            assign w_cur[k+1][r] = r_q[r];
         end
      end else begin : g_comb
         for (genvar r = 0; r < NO; r++) begin : g_o
            assign w_cur[k+1][r] = w_nxt[r];
         end
      end
      for (genvar r = NO; r < WIDTH; r++) begin : g_zero
         assign w_cur[k+1][r] = '0;
      end
   end

   // Flush clears every valid bit, out_valid included, whatever out_ready says.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NS; s++) r_ctl[s] <= '0;
      end else if (bus.flush) begin
         for (int s = 0; s < NS; s++) r_ctl[s].valid <= 1'b0;
      end else if (w_adv) begin
         r_ctl[0].valid <= w_acc;
         r_ctl[0].tag   <= MAX_TAG_W'(bus.in_tag);
         for (int s = 1; s < NS; s++) r_ctl[s] <= r_ctl[s-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_prod <= '0;
      else if (w_adv) r_prod <= w_cur[D][0] + w_cur[D][1];
   end

   assign bus.in_ready    = w_rdy;
   assign bus.out_valid   = r_ctl[NS-1].valid;
   assign bus.out_product = r_prod;
   assign bus.out_tag     = r_ctl[NS-1].tag[TAG_W-1:0];

endmodule

// File: tb/tb_pipelined_wallace_mul.sv
// Directed bench for pipelined_wallace_mul at WIDTH=32, LVL_PER_STAGE=2 (latency 6).
module tb_pipelined_wallace_mul;
   localparam int WIDTH = 32;
   localparam int TAG_W = 4;
   localparam int LPS   = 2;
   localparam int LAT   = 6;
   localparam int NV    = 12;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [63:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipelined_wallace_mul_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   pipelined_wallace_mul #(.WIDTH(WIDTH), .TAG_W(TAG_W), .LVL_PER_STAGE(LPS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   vec_t vt [NV];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      bus.in_a   = v.a;
      bus.in_b   = v.b;
      bus.in_tag = v.tag;
   endtask

   // Issue one op with out_ready high; check latency, product and tag.
   task automatic one_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [63:0] exp, input string nm);
      int lat;
      bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      #1;
      chk({nm, " in_ready at issue"}, 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      for (lat = 1; lat <= 20; lat++) begin
         if (bus.out_valid) break;
         chk({nm, " in_ready in flight"}, 64'(bus.in_ready), 64'd1);
         step();
      end
      chk({nm, " latency"}, 64'(lat), 64'(LAT));
      chk({nm, " product"}, bus.out_product, exp);
      chk({nm, " tag"}, 64'(bus.out_tag), 64'(tag));
      step();
   endtask

   // Push the whole table; out_ready is held low for cycles below stall_end.
   task automatic stream(input int stall_end, input string nm);
      int          in_idx;
      int          out_idx;
      int          first_c;
      int          last_c;
      logic [63:0] held;
      bit          holding;
      in_idx = 0; out_idx = 0; first_c = -1; last_c = -1; held = '0; holding = 0;
      for (int c = 0; c < 80 && out_idx < NV; c++) begin
         bus.out_ready = (c >= stall_end);
         bus.in_valid  = (in_idx < NV);
         if (in_idx < NV) drive(vt[in_idx]);
         #1;
         if (bus.out_valid && !bus.out_ready) begin
            chk({nm, " stall in_ready"}, 64'(bus.in_ready), 64'd0);
            if (holding) chk({nm, " stall hold"}, bus.out_product, held);
            held = bus.out_product;
            holding = 1;
         end
         if (bus.out_valid && bus.out_ready) begin
            chk({nm, " product"}, bus.out_product, vt[out_idx].exp);
            chk({nm, " tag"}, 64'(bus.out_tag), 64'(vt[out_idx].tag));
            if (first_c < 0) first_c = c;
            last_c = c;
            out_idx++;
         end
         if (bus.in_valid && bus.in_ready) in_idx++;
         step();
      end
      bus.in_valid = 1'b0;
      chk({nm, " accepted count"}, 64'(in_idx), 64'(NV));
      chk({nm, " result count"}, 64'(out_idx), 64'(NV));
      if (stall_end == 0) begin
         chk({nm, " first result cycle"}, 64'(first_c), 64'(LAT));
         chk({nm, " back-to-back span"}, 64'(last_c - first_c), 64'(NV - 1));
      end
      for (int c = 0; c < LAT + 2; c++) begin
         chk({nm, " no extra result"}, 64'(bus.out_valid), 64'd0);
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5,  64'hFFFFFFFE00000001};
      vt[1]  = '{32'h00000000, 32'h12345678, 4'd1,  64'h0000000000000000};
      vt[2]  = '{32'h00000001, 32'h00000001, 4'd2,  64'h0000000000000001};
      vt[3]  = '{32'h80000000, 32'h00000002, 4'd3,  64'h0000000100000000};
      vt[4]  = '{32'hFFFFFFFF, 32'h00000003, 4'd4,  64'h00000002FFFFFFFD};
      vt[5]  = '{32'h00010000, 32'h00010000, 4'd6,  64'h0000000100000000};
      vt[6]  = '{32'h12345678, 32'h00000010, 4'd7,  64'h0000000123456780};
      vt[7]  = '{32'h80000000, 32'h80000000, 4'd8,  64'h4000000000000000};
      vt[8]  = '{32'hFFFFFFFF, 32'h00000001, 4'd9,  64'h00000000FFFFFFFF};
      vt[9]  = '{32'h0000FFFF, 32'h0000FFFF, 4'd10, 64'h00000000FFFE0001};
      vt[10] = '{32'hDEADBEEF, 32'h00000002, 4'd11, 64'h00000001BD5B7DDE};
      vt[11] = '{32'h0000ABCD, 32'h00001000, 4'd12, 64'h000000000ABCD000};

      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b0;
`ifdef MUL_SIGNED_EN
      bus.in_signed = 1'b0;
`endif
      #2;
      chk("reset out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset out_product", bus.out_product, 64'd0);
      chk("reset out_tag", 64'(bus.out_tag), 64'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("in_ready after reset", 64'(bus.in_ready), 64'd1);
      step();

      one_op(vt[0].a, vt[0].b, vt[0].tag, vt[0].exp, "single max*max");

      stream(0, "stream");
      stream(LAT + 5, "backpressure");

      // Flush with four ops in flight and a fifth presented in the flush cycle.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(vt[i]); bus.in_valid = 1'b1;
         step();
      end
      drive(vt[4]); bus.in_valid = 1'b1; bus.flush = 1'b1;
      #1;
      chk("flush in_ready", 64'(bus.in_ready), 64'd0);
      step();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      chk("flush next out_valid", 64'(bus.out_valid), 64'd0);
      for (int c = 0; c < LAT + 2; c++) begin
         step();
         chk("flush residue", 64'(bus.out_valid), 64'd0);
      end
      one_op(vt[6].a, vt[6].b, vt[6].tag, vt[6].exp, "post flush");

`ifdef MUL_SIGNED_EN
      bus.in_signed = 1'b1;
      one_op(32'hFFFFFFFF, 32'h00000003, 4'd2, 64'hFFFFFFFFFFFFFFFD, "signed -1*3");
      one_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 64'h0000000000000001, "signed -1*-1");
      one_op(32'h80000000, 32'h80000000, 4'd4, 64'h4000000000000000, "signed min*min");
      one_op(32'h80000000, 32'h00000001, 4'd5, 64'hFFFFFFFF80000000, "signed min*1");
      bus.in_signed = 1'b0;
      one_op(32'hFFFFFFFF, 32'h00000003, 4'd6, 64'h00000002FFFFFFFD, "unsigned same ops");
`endif

      // Reset asserted mid-stream.
      bus.out_ready = 1'b1;
      for (int i = 0; i < LAT + 2; i++) begin
         drive(vt[i]); bus.in_valid = 1'b1;
         step();
      end
      chk("midstream out_valid before reset", 64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midstream reset out_valid", 64'(bus.out_valid), 64'd0);
      chk("midstream reset out_product", bus.out_product, 64'd0);
      chk("midstream reset out_tag", 64'(bus.out_tag), 64'd0);
      bus.in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("in_ready after midstream reset", 64'(bus.in_ready), 64'd1);
      for (int c = 0; c < LAT + 2; c++) begin
         step();
         chk("post reset no residue", 64'(bus.out_valid), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
